// File: rtl/mem_pkg.sv
// Shared types for the CPU data-memory responder: access sizes, the
// responder FSM states and the captured request bundle.
package mem_pkg;

  // Access width on the data bus; 2'b11 is not a member and is reported as an error.
  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_t;

  // Responder FSM: IDLE accepts, WAIT burns latency, RESP holds the response.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } resp_state_t;

  // Request as seen on the bus. size stays raw so the illegal 2'b11 encoding survives.
  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [1:0]  size;
    logic        unsigned_;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for sub-word accesses: store byte enables and lane
// replication, load lane select with sign/zero extension, and alignment check.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_word_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] rdata_ext_o,
  output logic        misaligned_o
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Pick the addressed byte and half out of the full RAM word.
  always_comb begin
    lane_byte = rdata_word_i[7:0];
    case (addr_lo_i)
      2'd0:    lane_byte = rdata_word_i[7:0];
      2'd1:    lane_byte = rdata_word_i[15:8];
      2'd2:    lane_byte = rdata_word_i[23:16];
      default: lane_byte = rdata_word_i[31:24];
    endcase
    lane_half = addr_lo_i[1] ? rdata_word_i[31:16] : rdata_word_i[15:0];
  end

  // Size-dependent enables, replication, extension; the illegal size is folded into misaligned.
  always_comb begin
    byte_en_o    = 4'b0000;
    wdata_rep_o  = wdata_i;
    rdata_ext_o  = 32'h0;
    misaligned_o = 1'b0;
    case (size_i)
      MEM_B: begin
        byte_en_o   = 4'b0001 << addr_lo_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
        rdata_ext_o = {{24{~unsigned_i & lane_byte[7]}}, lane_byte};
      end
      MEM_H: begin
        byte_en_o    = 4'b0011 << addr_lo_i;
        wdata_rep_o  = {2{wdata_i[15:0]}};
        rdata_ext_o  = {{16{~unsigned_i & lane_half[15]}}, lane_half};
        misaligned_o = addr_lo_i[0];
      end
      MEM_W: begin
        byte_en_o    = 4'b1111;
        wdata_rep_o  = wdata_i;
        rdata_ext_o  = rdata_word_i;
        misaligned_o = |addr_lo_i;
      end
      default: begin
        misaligned_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory bus. One request outstanding at a time.
// Handshake: a request is taken on a posedge where req_valid && req_ready; a
// response is taken on a posedge where resp_valid && resp_ready, and resp_*
// hold steady while resp_valid && !resp_ready. req_ready is high only in IDLE.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output resp_state_t dbg_state
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam int unsigned CW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);
  // Window size in bytes, kept 33 bits wide so a window reaching 4 GiB does not wrap.
  localparam logic [32:0] WIN_BYTES = 33'(DEPTH_WORDS) << 2;

  mem_req_t    req;
  resp_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic        accept;
  logic [31:0] addr_off;
  logic        in_range;
  logic        misaligned;
  logic        req_err;
  logic [AW-1:0] word_idx;
  logic [31:0] rdata_word;
  logic [3:0]  byte_en;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_ext;

  assign req = '{addr: req_addr, wen: req_wen, size: req_size,
                 unsigned_: req_unsigned, wdata: req_wdata};

  // Range check on the full offset before truncating it to a word index.
  assign addr_off   = req.addr - BASE_ADDR;
  assign in_range   = (req.addr >= BASE_ADDR) && ({1'b0, addr_off} < WIN_BYTES);
  assign word_idx   = addr_off[AW+1:2];
  assign rdata_word = mem_q[word_idx];
  assign req_err    = misaligned || !in_range;

  assign req_ready  = (state_q == IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dbg_state  = state_q;

  mem_lane_align u_align (
    .size_i       (req.size),
    .addr_lo_i    (req.addr[1:0]),
    .unsigned_i   (req.unsigned_),
    .wdata_i      (req.wdata),
    .rdata_word_i (rdata_word),
    .byte_en_o    (byte_en),
    .wdata_rep_o  (wdata_rep),
    .rdata_ext_o  (rdata_ext),
    .misaligned_o (misaligned)
  );

  // Next state, latency counter and response capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          err_d   = req_err;
          rdata_d = (req.wen || req_err) ? 32'h0 : rdata_ext;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers; reset abandons any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM write on the accept edge through byte enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && req.wen && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_q[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

endmodule
